// File: rtl/wb_master_pkg.sv
// Shared types and defaults for the Wishbone burst initiator.
package wb_master_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    REQ   = 3'd2,
    HOLD  = 3'd3,
    FIN   = 3'd4
  } state_t;

  localparam logic [3:0] SEL_ALL = 4'hF;

  localparam int ADDR_W_DEF    = 24;
  localparam int DATA_W_DEF    = 32;
  localparam int LEN_W_DEF     = 8;
  localparam int ADDR_STEP_DEF = 4;

endpackage

// File: rtl/wb_burst_master.sv
// Wishbone classic-cycle burst initiator: one single-beat transfer per word at incrementing addresses.
// Optional ack timeout enabled by defining WB_BURST_MASTER_TIMEOUT_EN.
module wb_burst_master
  import wb_master_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int LEN_W          = LEN_W_DEF,
  parameter int ADDR_STEP      = ADDR_STEP_DEF,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              err,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [3:0]        wbm_sel_o,
  output logic [ADDR_W-1:0] wbm_adr_o,
  output logic [DATA_W-1:0] wbm_dat_o,
  input  logic              wbm_ack_i,
  input  logic [DATA_W-1:0] wbm_dat_i
);

  state_t            state, state_n;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  rem_q;
  logic [DATA_W-1:0] dat_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              cyc, stb;
  logic              timeout;

`ifdef WB_BURST_MASTER_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt;
  logic       err_q;
`endif

  always_comb begin
    state_n   = state;
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    rd_valid  = 1'b0;
    done      = 1'b0;
    cyc       = 1'b0;
    stb       = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_len == '0) state_n = FIN;
          else if (cmd_we)   state_n = FETCH;
          else               state_n = REQ;
        end
      end
      FETCH: begin
        cyc      = 1'b1;
        wr_ready = 1'b1;
        if (wr_valid) state_n = REQ;
      end
      REQ: begin
        cyc = 1'b1;
        stb = 1'b1;
        if (wbm_ack_i) begin
          if (!we_q)                   state_n = HOLD;
          else if (rem_q == LEN_W'(1)) state_n = FIN;
          else                         state_n = FETCH;
        end
`ifdef WB_BURST_MASTER_TIMEOUT_EN
        else if (wait_cnt == TO_LAST) begin
          timeout = 1'b1;
          state_n = FIN;
        end
`endif
      end
      HOLD: begin
        cyc      = 1'b1;
        rd_valid = 1'b1;
        if (rd_ready) state_n = (rem_q == '0) ? FIN : REQ;
      end
      FIN: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      rem_q     <= '0;
      dat_q     <= '0;
      rd_data_q <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && cmd_valid) begin
        we_q   <= cmd_we;
        addr_q <= cmd_addr;
        rem_q  <= cmd_len;
      end
      if (state == FETCH && wr_valid) dat_q <= wr_data;
      if (state == REQ && wbm_ack_i) begin
        addr_q <= addr_q + ADDR_W'(ADDR_STEP);
        rem_q  <= rem_q - LEN_W'(1);
        if (!we_q) rd_data_q <= wbm_dat_i;
      end
    end
  end

`ifdef WB_BURST_MASTER_TIMEOUT_EN
  // Counter is held at zero outside REQ so every REQ entry starts a fresh wait.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state != REQ || wbm_ack_i) wait_cnt <= '0;
      else                           wait_cnt <= wait_cnt + 8'd1;
      if (state == IDLE && cmd_valid) err_q <= 1'b0;
      else if (timeout)               err_q <= 1'b1;
    end
  end

  assign err = (state == FIN) && err_q;
`else
  assign err = 1'b0;
`endif

  assign rd_data   = rd_data_q;
  assign wbm_cyc_o = cyc;
  assign wbm_stb_o = stb;
  assign wbm_we_o  = cyc && we_q;
  assign wbm_sel_o = stb ? SEL_ALL : 4'h0;
  assign wbm_adr_o = addr_q;
  assign wbm_dat_o = dat_q;

endmodule

// File: tb/tb_wb_burst_master.sv
// Scoreboard bench for wb_burst_master: stimulus queues expected bus/read/done events, a monitor checks them.
module tb_wb_burst_master;
  import wb_master_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [23:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid, rd_ready;
  logic [31:0] rd_data;
  logic        done, err;
  logic        cyc, stb, we_o;
  logic [3:0]  sel;
  logic [23:0] adr;
  logic [31:0] dat_o;
  logic        ack;
  logic [31:0] dat_i;

  always #5 clk = ~clk;

  wb_burst_master #(.TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done), .err(err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we_o), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_ack_i(ack), .wbm_dat_i(dat_i)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  localparam int EV_WR = 0, EV_RD = 1, EV_RDATA = 2, EV_DONE = 3;
  typedef struct {
    int          kind;
    logic [23:0] adr;
    logic [31:0] dat;
    logic        err;
  } ev_t;
  ev_t sb[$];

  task automatic expect_ev(input int kind, input logic [23:0] a, input logic [31:0] d, input logic e);
    ev_t ev;
    ev.kind = kind; ev.adr = a; ev.dat = d; ev.err = e;
    sb.push_back(ev);
  endtask

  // Slave: registered ack one cycle after it samples stb; read data from rd_tbl in order.
  logic        ack_en;
  logic [31:0] rd_tbl [16];
  logic [31:0] wr_tbl [16];
  int          rd_idx = 0;
  int          wr_idx = 0;

  always @(posedge clk) begin
    if (rst) ack <= 1'b0;
    else if (stb && !ack && ack_en) begin
      ack <= 1'b1;
      if (!we_o) begin
        dat_i  <= rd_tbl[rd_idx];
        rd_idx <= rd_idx + 1;
      end
    end else ack <= 1'b0;
  end

  always @(posedge clk) if (!rst && wr_valid && wr_ready) wr_idx <= wr_idx + 1;
  assign wr_data = wr_tbl[wr_idx[3:0]];

  task automatic pop_cmp(input int kind, input logic [23:0] a, input logic [31:0] d, input logic e);
    ev_t ev;
    n_checks++;
    if (sb.size() == 0) begin
      $display("FAIL unexpected_event: got kind %0d adr %0h dat %0h, expected none", kind, a, d);
      return;
    end
    n_pass++;
    ev = sb.pop_front();
    check("ev_kind", 64'(kind), 64'(ev.kind));
    case (kind)
      EV_WR:    begin check("wr_adr", 64'(a), 64'(ev.adr)); check("wr_dat", 64'(d), 64'(ev.dat)); end
      EV_RD:    check("rd_adr", 64'(a), 64'(ev.adr));
      EV_RDATA: check("rd_data", 64'(d), 64'(ev.dat));
      default:  check("done_err", 64'(e), 64'(ev.err));
    endcase
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (stb && ack) begin
        check("sel_all", 64'(sel), 64'(SEL_ALL));
        pop_cmp(we_o ? EV_WR : EV_RD, adr, dat_o, 1'b0);
      end
      if (rd_valid && rd_ready) pop_cmp(EV_RDATA, '0, rd_data, 1'b0);
      if (done) pop_cmp(EV_DONE, '0, '0, err);
      if (err && !done) check("err_without_done", 64'(err), 64'(done));
    end
  end

  task automatic cyc_wait();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic we, input logic [23:0] a, input logic [7:0] n);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_len = n;
    cyc_wait();
    cmd_valid = 1'b0;
  endtask

  // Runs from the first cycle after accept until done or budget; reports latency and bus activity.
  task automatic wait_done(input int budget, output int lat, output int cyc_lo, output int cyc_hi,
                           output int stb_n);
    lat = 1; cyc_lo = 0; cyc_hi = 0; stb_n = 0;
    while (!done && lat < budget) begin
      if (cyc) cyc_hi++; else cyc_lo++;
      if (stb) stb_n++;
      cyc_wait();
      lat++;
    end
    check("done_seen", 64'(done), 64'(1));
  endtask

  task automatic after_done();
    check("done_cleared", 64'(done), 64'(0));
    check("cmd_ready_back", 64'(cmd_ready), 64'(1));
  endtask

  int lat, cyc_lo, cyc_hi, stb_n, bad, guard;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; rd_ready = 1'b0; ack_en = 1'b1; dat_i = '0;
    for (int i = 0; i < 16; i++) begin rd_tbl[i] = '0; wr_tbl[i] = '0; end
    repeat (2) cyc_wait();
    check("rst_cyc_stb_we", {61'd0, cyc, stb, we_o}, 64'd0);
    check("rst_sel_adr", {36'd0, sel, adr}, 64'd0);
    check("rst_dat_o", 64'(dat_o), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_flags", {60'd0, wr_ready, rd_valid, done, err}, 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    rst = 1'b0;
    cyc_wait();

    // Write burst of three words.
    wr_tbl[wr_idx[3:0]] = 32'hA; wr_tbl[wr_idx[3:0] + 4'd1] = 32'hB; wr_tbl[wr_idx[3:0] + 4'd2] = 32'hC;
    expect_ev(EV_WR, 24'h000100, 32'hA, 1'b0);
    expect_ev(EV_WR, 24'h000104, 32'hB, 1'b0);
    expect_ev(EV_WR, 24'h000108, 32'hC, 1'b0);
    expect_ev(EV_DONE, '0, '0, 1'b0);
    wr_valid = 1'b1;
    issue(1'b1, 24'h000100, 8'd3);
    wait_done(100, lat, cyc_lo, cyc_hi, stb_n);
    check("wr_cyc_held", 64'(cyc_lo), 64'd0);
    check("wr_stb_cycles", 64'(stb_n), 64'd6);
    check("fin_cyc_low", 64'(cyc), 64'd0);
    cyc_wait();
    after_done();
    wr_valid = 1'b0;

    // Read burst, first word held off for 5 cycles.
    rd_tbl[rd_idx[3:0]] = 32'h11; rd_tbl[rd_idx[3:0] + 4'd1] = 32'h22;
    expect_ev(EV_RD, 24'h000200, '0, 1'b0);
    expect_ev(EV_RDATA, '0, 32'h11, 1'b0);
    expect_ev(EV_RD, 24'h000204, '0, 1'b0);
    expect_ev(EV_RDATA, '0, 32'h22, 1'b0);
    expect_ev(EV_DONE, '0, '0, 1'b0);
    issue(1'b0, 24'h000200, 8'd2);
    guard = 0;
    while (!rd_valid && guard < 50) begin cyc_wait(); guard++; end
    check("rd_valid_seen", 64'(rd_valid), 64'd1);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (!rd_valid || rd_data !== 32'h11 || stb || !cyc) bad++;
      cyc_wait();
    end
    check("rd_backpressure_hold", 64'(bad), 64'd0);
    rd_ready = 1'b1;
    wait_done(100, lat, cyc_lo, cyc_hi, stb_n);
    check("rd_cyc_held", 64'(cyc_lo), 64'd0);
    cyc_wait();
    after_done();
    rd_ready = 1'b0;

    // Zero-length command.
    expect_ev(EV_DONE, '0, '0, 1'b0);
    issue(1'b1, 24'h000500, 8'd0);
    wait_done(10, lat, cyc_lo, cyc_hi, stb_n);
    check("zero_len_no_cyc", 64'(cyc_hi + (cyc ? 1 : 0)), 64'd0);
    check("zero_len_latency_ok", 64'(lat >= 1 && lat <= 2), 64'd1);
    cyc_wait();
    after_done();

    // Address wrap at the top of the space.
    wr_tbl[wr_idx[3:0]] = 32'h1; wr_tbl[wr_idx[3:0] + 4'd1] = 32'h2;
    expect_ev(EV_WR, 24'hFFFFFC, 32'h1, 1'b0);
    expect_ev(EV_WR, 24'h000000, 32'h2, 1'b0);
    expect_ev(EV_DONE, '0, '0, 1'b0);
    wr_valid = 1'b1;
    issue(1'b1, 24'hFFFFFC, 8'd2);
    wait_done(100, lat, cyc_lo, cyc_hi, stb_n);
    cyc_wait();
    after_done();
    wr_valid = 1'b0;

    // Reset while a read transfer is waiting for ack.
    ack_en = 1'b0;
    issue(1'b0, 24'h000300, 8'd2);
    guard = 0;
    while (!stb && guard < 20) begin cyc_wait(); guard++; end
    check("req_reached", 64'(stb), 64'd1);
    rst = 1'b1;
    cyc_wait();
    check("mid_rst_cyc_stb_done", {61'd0, cyc, stb, done}, 64'd0);
    check("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("mid_rst_rd_valid", 64'(rd_valid), 64'd0);
    rst = 1'b0;
    cyc_wait();

`ifdef WB_BURST_MASTER_TIMEOUT_EN
    expect_ev(EV_DONE, '0, '0, 1'b1);
    issue(1'b0, 24'h000400, 8'd1);
    wait_done(50, lat, cyc_lo, cyc_hi, stb_n);
    check("timeout_req_cycles", 64'(stb_n), 64'd8);
    check("timeout_err_with_done", 64'(err), 64'd1);
    check("timeout_stb_low", 64'(stb), 64'd0);
    cyc_wait();
    after_done();
`endif
    ack_en = 1'b1;

    repeat (3) cyc_wait();
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
